// File: rtl/legv8_multicycle_ctrl.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing, NZ flags, branch resolve.
// Latency: R/I 4 cycles, LD 5+waits, ST 4+waits, branches 3; outputs combinational from state/class.
// Backpressure: MEM holds its request until i_memAck; MEM_TIMEOUT cycles without ack halt with o_busErr.
module legv8_multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [10:0] i_opCode,
  input  logic [3:0]  i_bCond,
  input  logic        i_Z,
  input  logic        i_N,
  input  logic        i_memAck,
  output logic        o_irWr,
  output logic        o_pcWr,
  output logic [1:0]  o_PCSrc,
  output logic        o_reg2Sel,
  output logic        o_rfWr,
  output logic [1:0]  o_SEU,
  output logic        o_ALUSrcB,
  output logic [3:0]  o_ALUOp,
  output logic        o_memRd,
  output logic        o_memWr,
  output logic [1:0]  o_wrDataSel,
  output logic [2:0]  o_state,
  output logic        o_instRet,
  output logic        o_illegal,
  output logic        o_busErr
);

  localparam int          CW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned TMO_LAST = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [4:0] {
    C_ADD, C_SUB, C_AND, C_ORR, C_LSL, C_LSR, C_ADDS, C_SUBS,
    C_ADDI, C_SUBI, C_SUBIS, C_LD, C_ST, C_B, C_BL, C_BCOND,
    C_CBZ, C_CBNZ, C_BR, C_BAD
  } cls_t;

  state_t          r_state, nxt_state;
  cls_t            r_cls, dec_cls;
  logic            r_Z, r_N;
  logic [CW-1:0]   r_cnt;
  logic            r_illegal, r_busErr;

  logic            irWr, pcWr, reg2Sel, rfWr, aluSrcB, memRd, memWr, instRet;
  logic [1:0]      pcSrc, seu, wrDataSel;
  logic [3:0]      aluOp;

  logic [3:0]      ri_op;
  logic            ri_imm, ri_cls, ri_flags;
  logic            cond_ok, tmo_hit;

  // Branch/immediate formats are matched on their short opcode prefixes first.
  always_comb begin
    dec_cls = C_BAD;
    if (i_opCode[10:5] == 6'b000101)             dec_cls = C_B;
    else if (i_opCode[10:5] == 6'b100101)        dec_cls = C_BL;
    else if (i_opCode[10:3] == 8'b01010100)      dec_cls = C_BCOND;
    else if (i_opCode[10:3] == 8'b10110100)      dec_cls = C_CBZ;
    else if (i_opCode[10:3] == 8'b10110101)      dec_cls = C_CBNZ;
    else if (i_opCode[10:1] == 10'b1001000100)   dec_cls = C_ADDI;
    else if (i_opCode[10:1] == 10'b1101000100)   dec_cls = C_SUBI;
    else if (i_opCode[10:1] == 10'b1111000100)   dec_cls = C_SUBIS;
    else begin
      case (i_opCode)
        11'b10001011000: dec_cls = C_ADD;
        11'b11001011000: dec_cls = C_SUB;
        11'b10001010000: dec_cls = C_AND;
        11'b10101010000: dec_cls = C_ORR;
        11'b11010011011: dec_cls = C_LSL;
        11'b11010011010: dec_cls = C_LSR;
        11'b10101011000: dec_cls = C_ADDS;
        11'b11101011000: dec_cls = C_SUBS;
        11'b11111000010: dec_cls = C_LD;
        11'b11111000000: dec_cls = C_ST;
        11'b11010110000: dec_cls = C_BR;
        default:         dec_cls = C_BAD;
      endcase
    end
  end

  always_comb begin
    ri_op    = 4'd0;
    ri_imm   = 1'b0;
    ri_cls   = 1'b1;
    ri_flags = 1'b0;
    case (r_cls)
      C_ADD:   ri_op = 4'd0;
      C_SUB:   ri_op = 4'd1;
      C_AND:   ri_op = 4'd2;
      C_ORR:   ri_op = 4'd3;
      C_LSL:   ri_op = 4'd6;
      C_LSR:   ri_op = 4'd7;
      C_ADDS:  ri_flags = 1'b1;
      C_SUBS:  begin ri_op = 4'd1; ri_flags = 1'b1; end
      C_ADDI:  ri_imm = 1'b1;
      C_SUBI:  begin ri_op = 4'd1; ri_imm = 1'b1; end
      C_SUBIS: begin ri_op = 4'd1; ri_imm = 1'b1; ri_flags = 1'b1; end
      default: ri_cls = 1'b0;
    endcase
  end

  always_comb begin
    case (i_bCond)
      4'b0000: cond_ok = r_Z;
      4'b0001: cond_ok = !r_Z;
      4'b1010: cond_ok = !r_N;
      4'b1011: cond_ok = r_N;
      4'b1100: cond_ok = !r_Z && !r_N;
      4'b1101: cond_ok = r_Z || r_N;
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  assign tmo_hit = (MEM_TIMEOUT != 0) && (32'(r_cnt) == TMO_LAST);

  always_comb begin
    nxt_state = r_state;
    irWr      = 1'b0;
    pcWr      = 1'b0;
    pcSrc     = 2'd0;
    reg2Sel   = 1'b0;
    rfWr      = 1'b0;
    seu       = 2'd0;
    aluSrcB   = 1'b0;
    aluOp     = 4'd0;
    memRd     = 1'b0;
    memWr     = 1'b0;
    wrDataSel = 2'd0;
    instRet   = 1'b0;
    case (r_state)
      S_FETCH: begin
        irWr      = 1'b1;
        pcWr      = 1'b1;
        nxt_state = S_DECODE;
      end
      S_DECODE: nxt_state = (dec_cls == C_BAD) ? S_HALT : S_EXEC;
      S_EXEC: begin
        nxt_state = S_FETCH;
        if (ri_cls) begin
          aluOp     = ri_op;
          aluSrcB   = ri_imm;
          nxt_state = S_WB;
        end else begin
          case (r_cls)
            C_LD, C_ST: begin
              aluSrcB   = 1'b1;
              seu       = 2'd1;
              reg2Sel   = (r_cls == C_ST);
              nxt_state = S_MEM;
            end
            C_B, C_BL: begin
              seu     = 2'd2;
              pcWr    = 1'b1;
              pcSrc   = 2'd1;
              instRet = 1'b1;
              if (r_cls == C_BL) begin
                rfWr      = 1'b1;
                wrDataSel = 2'd2;
              end
            end
            C_CBZ, C_CBNZ: begin
              reg2Sel = 1'b1;
              aluOp   = 4'd8;
              seu     = 2'd3;
              instRet = 1'b1;
              if ((r_cls == C_CBZ) == i_Z) begin
                pcWr  = 1'b1;
                pcSrc = 2'd1;
              end
            end
            C_BCOND: begin
              seu     = 2'd3;
              instRet = 1'b1;
              if (cond_ok) begin
                pcWr  = 1'b1;
                pcSrc = 2'd1;
              end
            end
            C_BR: begin
              reg2Sel = 1'b1;
              pcSrc   = 2'd2;
              pcWr    = 1'b1;
              instRet = 1'b1;
            end
            default: nxt_state = S_HALT;
          endcase
        end
      end
      S_MEM: begin
        if (r_cls == C_ST) begin
          memWr   = 1'b1;
          reg2Sel = 1'b1;
        end else begin
          memRd   = 1'b1;
          aluSrcB = 1'b1;
          seu     = 2'd1;
        end
        if (i_memAck) begin
          nxt_state = (r_cls == C_ST) ? S_FETCH : S_WB;
          instRet   = (r_cls == C_ST);
        end else if (tmo_hit) begin
          nxt_state = S_HALT;
        end
      end
      S_WB: begin
        rfWr      = 1'b1;
        instRet   = 1'b1;
        nxt_state = S_FETCH;
        if (r_cls != C_LD) begin
          wrDataSel = 2'd1;
          aluOp     = ri_op;
          aluSrcB   = ri_imm;
        end
      end
      S_HALT:  nxt_state = S_HALT;
      default: nxt_state = S_HALT;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_FETCH;
      r_cls     <= C_ADD;
      r_Z       <= 1'b0;
      r_N       <= 1'b0;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_busErr  <= 1'b0;
    end else begin
      r_state <= nxt_state;
      if (r_state == S_DECODE) begin
        r_cls <= dec_cls;
        if (dec_cls == C_BAD) r_illegal <= 1'b1;
      end
      if (r_state == S_EXEC && ri_cls && ri_flags) begin
        r_Z <= i_Z;
        r_N <= i_N;
      end
      // Counter only runs while we stay in MEM; any exit clears it.
      if (r_state == S_MEM && nxt_state == S_MEM) r_cnt <= r_cnt + CW'(1);
      else                                        r_cnt <= '0;
      if (r_state == S_MEM && nxt_state == S_HALT) r_busErr <= 1'b1;
    end
  end

  // Reset forces every output low without waiting for a clock edge.
  assign o_irWr      = i_rst_n & irWr;
  assign o_pcWr      = i_rst_n & pcWr;
  assign o_PCSrc     = {2{i_rst_n}} & pcSrc;
  assign o_reg2Sel   = i_rst_n & reg2Sel;
  assign o_rfWr      = i_rst_n & rfWr;
  assign o_SEU       = {2{i_rst_n}} & seu;
  assign o_ALUSrcB   = i_rst_n & aluSrcB;
  assign o_ALUOp     = {4{i_rst_n}} & aluOp;
  assign o_memRd     = i_rst_n & memRd;
  assign o_memWr     = i_rst_n & memWr;
  assign o_wrDataSel = {2{i_rst_n}} & wrDataSel;
  assign o_state     = {3{i_rst_n}} & r_state;
  assign o_instRet   = i_rst_n & instRet;
  assign o_illegal   = i_rst_n & r_illegal;
  assign o_busErr    = i_rst_n & r_busErr;

endmodule

// File: tb/tb_legv8_multicycle_ctrl.sv
// Directed bench for legv8_multicycle_ctrl: per-cycle expected control words queued, then compared at negedge.
module tb_legv8_multicycle_ctrl;

  typedef struct packed {
    logic [2:0] state;
    logic       irWr;
    logic       pcWr;
    logic [1:0] pcSrc;
    logic       reg2Sel;
    logic       rfWr;
    logic [1:0] seu;
    logic       aluSrcB;
    logic [3:0] aluOp;
    logic       memRd;
    logic       memWr;
    logic [1:0] wrDataSel;
    logic       instRet;
    logic       illegal;
    logic       busErr;
  } ctl_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [10:0] i_opCode;
  logic [3:0]  i_bCond;
  logic        i_Z, i_N, i_memAck;
  logic        o_irWr, o_pcWr, o_reg2Sel, o_rfWr, o_ALUSrcB, o_memRd, o_memWr;
  logic        o_instRet, o_illegal, o_busErr;
  logic [1:0]  o_PCSrc, o_SEU, o_wrDataSel;
  logic [3:0]  o_ALUOp;
  logic [2:0]  o_state;

  int vectors = 0;
  int miscompares = 0;
  ctl_t  sb_q[$];
  string tag_q[$];
  ctl_t  obs;

  localparam logic [10:0] OP_ADD   = 11'b10001011000;
  localparam logic [10:0] OP_SUB   = 11'b11001011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_SUBIS = 11'b11110001000;
  localparam logic [10:0] OP_LD    = 11'b11111000010;
  localparam logic [10:0] OP_ST    = 11'b11111000000;
  localparam logic [10:0] OP_BC    = 11'b01010100000;
  localparam logic [10:0] OP_CBZ   = 11'b10110100000;
  localparam logic [10:0] OP_CBNZ  = 11'b10110101000;
  localparam logic [10:0] OP_B     = 11'b00010100000;
  localparam logic [10:0] OP_BL    = 11'b10010100000;
  localparam logic [10:0] OP_BR    = 11'b11010110000;

  // R/I table: opcode, expected ALUOp, immediate operand
  logic [10:0] ri_opc [8] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
                              11'b11010011011, 11'b11010011010, 11'b10010001000, 11'b11010001000};
  logic [3:0]  ri_alu [8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd0, 4'd1};
  logic        ri_imm [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  // Condition table evaluated with flags Z=0, N=1
  logic [3:0]  cc_code [7] = '{4'b1011, 4'b1010, 4'b1101, 4'b1100, 4'b1110, 4'b1111, 4'b0001};
  logic        cc_take [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  legv8_multicycle_ctrl #(.MEM_TIMEOUT(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_opCode(i_opCode), .i_bCond(i_bCond),
    .i_Z(i_Z), .i_N(i_N), .i_memAck(i_memAck),
    .o_irWr(o_irWr), .o_pcWr(o_pcWr), .o_PCSrc(o_PCSrc), .o_reg2Sel(o_reg2Sel),
    .o_rfWr(o_rfWr), .o_SEU(o_SEU), .o_ALUSrcB(o_ALUSrcB), .o_ALUOp(o_ALUOp),
    .o_memRd(o_memRd), .o_memWr(o_memWr), .o_wrDataSel(o_wrDataSel), .o_state(o_state),
    .o_instRet(o_instRet), .o_illegal(o_illegal), .o_busErr(o_busErr)
  );

  always #5 i_clk = ~i_clk;

  assign obs = {o_state, o_irWr, o_pcWr, o_PCSrc, o_reg2Sel, o_rfWr, o_SEU, o_ALUSrcB,
                o_ALUOp, o_memRd, o_memWr, o_wrDataSel, o_instRet, o_illegal, o_busErr};

  function automatic ctl_t st(input logic [2:0] s);
    ctl_t c;
    c = '0;
    c.state = s;
    return c;
  endfunction

  task automatic push(input string t, input ctl_t e);
    sb_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic check_now();
    ctl_t  e;
    string t;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    vectors++;
    assert (obs === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", t, obs, e);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    check_now();
    @(posedge i_clk);
    #1;
  endtask

  task automatic fd(input string t);
    ctl_t e;
    e = st(3'd0); e.irWr = 1'b1; e.pcWr = 1'b1;
    push({t, "_fetch"}, e); step();
    push({t, "_decode"}, st(3'd1)); step();
  endtask

  task automatic rst_pulse(input string t);
    i_rst_n = 1'b0;
    #1;
    push({t, "_rst_now"}, st(3'd0)); check_now();
    @(negedge i_clk);
    push({t, "_rst_hold"}, st(3'd0)); check_now();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
  endtask

  initial begin
    ctl_t e;
    i_rst_n = 1'b0; i_opCode = '0; i_bCond = '0; i_Z = 1'b0; i_N = 1'b0; i_memAck = 1'b0;
    #2;
    push("reset", st(3'd0)); check_now();
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;

    // ADD: 4 cycles, retire in WB
    i_opCode = OP_ADD; fd("add");
    push("add_exec", st(3'd2)); step();
    e = st(3'd4); e.rfWr = 1'b1; e.wrDataSel = 2'd1; e.instRet = 1'b1;
    push("add_wb", e); step();

    // LDUR, ack after 2 wait cycles: 7 cycles
    i_opCode = OP_LD; fd("ld");
    e = st(3'd2); e.aluSrcB = 1'b1; e.seu = 2'd1; push("ld_exec", e); step();
    e = st(3'd3); e.aluSrcB = 1'b1; e.seu = 2'd1; e.memRd = 1'b1;
    push("ld_wait0", e); step();
    push("ld_wait1", e); step();
    i_memAck = 1'b1; push("ld_ack", e); step();
    i_memAck = 1'b0;
    e = st(3'd4); e.rfWr = 1'b1; e.instRet = 1'b1; push("ld_wb", e); step();

    // LDUR with ack held high throughout: no effect outside MEM, zero waits
    i_memAck = 1'b1; i_opCode = OP_LD; fd("ld0");
    e = st(3'd2); e.aluSrcB = 1'b1; e.seu = 2'd1; push("ld0_exec", e); step();
    e = st(3'd3); e.aluSrcB = 1'b1; e.seu = 2'd1; e.memRd = 1'b1; push("ld0_mem", e); step();
    i_memAck = 1'b0;
    e = st(3'd4); e.rfWr = 1'b1; e.instRet = 1'b1; push("ld0_wb", e); step();

    // R and I class ALU decode
    for (int k = 0; k < 8; k++) begin
      i_opCode = ri_opc[k]; fd("ri");
      e = st(3'd2); e.aluOp = ri_alu[k]; e.aluSrcB = ri_imm[k]; push("ri_exec", e); step();
      e = st(3'd4); e.aluOp = ri_alu[k]; e.aluSrcB = ri_imm[k];
      e.rfWr = 1'b1; e.wrDataSel = 2'd1; e.instRet = 1'b1;
      push("ri_wb", e); step();
    end

    // SUBIS sets Z=1
    i_opCode = OP_SUBIS; fd("subis");
    i_Z = 1'b1; i_N = 1'b0;
    e = st(3'd2); e.aluOp = 4'd1; e.aluSrcB = 1'b1; push("subis_exec", e); step();
    i_Z = 1'b0;
    e.state = 3'd4; e.rfWr = 1'b1; e.wrDataSel = 2'd1; e.instRet = 1'b1; push("subis_wb", e); step();

    i_opCode = OP_BC; i_bCond = 4'b0000; fd("beq");
    e = st(3'd2); e.seu = 2'd3; e.instRet = 1'b1; e.pcWr = 1'b1; e.pcSrc = 2'd1;
    push("beq_taken", e); step();
    i_bCond = 4'b0001; fd("bne");
    e = st(3'd2); e.seu = 2'd3; e.instRet = 1'b1; push("bne_not_taken", e); step();

    // Plain SUB must not touch the flags
    i_opCode = OP_SUB; fd("sub");
    i_Z = 1'b0; i_N = 1'b1;
    e = st(3'd2); e.aluOp = 4'd1; push("sub_exec", e); step();
    e.state = 3'd4; e.rfWr = 1'b1; e.wrDataSel = 2'd1; e.instRet = 1'b1; push("sub_wb", e); step();
    i_opCode = OP_BC; i_bCond = 4'b0000; fd("beq2");
    e = st(3'd2); e.seu = 2'd3; e.instRet = 1'b1; e.pcWr = 1'b1; e.pcSrc = 2'd1;
    push("beq_flags_kept", e); step();

    // SUBS sets Z=0 N=1, then walk condition codes
    i_opCode = OP_SUBS; fd("subs");
    e = st(3'd2); e.aluOp = 4'd1; push("subs_exec", e); step();
    i_N = 1'b0;
    e.state = 3'd4; e.rfWr = 1'b1; e.wrDataSel = 2'd1; e.instRet = 1'b1; push("subs_wb", e); step();
    for (int k = 0; k < 7; k++) begin
      i_opCode = OP_BC; i_bCond = cc_code[k]; fd("bcond");
      e = st(3'd2); e.seu = 2'd3; e.instRet = 1'b1;
      if (cc_take[k]) begin e.pcWr = 1'b1; e.pcSrc = 2'd1; end
      push("bcond_exec", e); step();
    end

    // Compare-and-branch on live Z
    i_opCode = OP_CBNZ; fd("cbnz");
    i_Z = 1'b1;
    e = st(3'd2); e.reg2Sel = 1'b1; e.aluOp = 4'd8; e.seu = 2'd3; e.instRet = 1'b1;
    push("cbnz_not_taken", e); step();
    i_opCode = OP_CBZ; fd("cbz");
    e.pcWr = 1'b1; e.pcSrc = 2'd1; push("cbz_taken", e); step();
    i_opCode = OP_CBNZ; fd("cbnz2");
    i_Z = 1'b0; push("cbnz_taken", e); step();

    i_opCode = OP_BL; fd("bl");
    e = st(3'd2); e.seu = 2'd2; e.pcWr = 1'b1; e.pcSrc = 2'd1; e.rfWr = 1'b1;
    e.wrDataSel = 2'd2; e.instRet = 1'b1; push("bl_exec", e); step();
    i_opCode = OP_B; fd("b");
    e = st(3'd2); e.seu = 2'd2; e.pcWr = 1'b1; e.pcSrc = 2'd1; e.instRet = 1'b1;
    push("b_exec", e); step();
    i_opCode = OP_BR; fd("br");
    e = st(3'd2); e.reg2Sel = 1'b1; e.pcSrc = 2'd2; e.pcWr = 1'b1; e.instRet = 1'b1;
    push("br_exec", e); step();

    // STUR with one wait cycle
    i_opCode = OP_ST; fd("st");
    e = st(3'd2); e.aluSrcB = 1'b1; e.seu = 2'd1; e.reg2Sel = 1'b1; push("st_exec", e); step();
    e = st(3'd3); e.memWr = 1'b1; e.reg2Sel = 1'b1; push("st_wait", e); step();
    i_memAck = 1'b1; e.instRet = 1'b1; push("st_ack", e); step();
    i_memAck = 1'b0;

    // STUR timeout: exactly 16 MEM cycles then HALT with bus error
    fd("sttmo");
    e = st(3'd2); e.aluSrcB = 1'b1; e.seu = 2'd1; e.reg2Sel = 1'b1; push("sttmo_exec", e); step();
    e = st(3'd3); e.memWr = 1'b1; e.reg2Sel = 1'b1;
    for (int k = 0; k < 16; k++) begin
      push("sttmo_mem", e); step();
    end
    i_memAck = 1'b1;
    e = st(3'd7); e.busErr = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push("busErr_halt", e); step();
    end
    i_memAck = 1'b0;
    rst_pulse("busErr");

    // Illegal opcode halts until reset
    i_opCode = 11'b00000000000; fd("ill");
    e = st(3'd7); e.illegal = 1'b1;
    push("ill_halt0", e); step();
    i_opCode = OP_ADD;
    push("ill_halt1", e); step();
    push("ill_halt2", e); step();
    rst_pulse("ill");

    // Reset asserted mid-MEM drops memWr without a clock
    i_opCode = OP_ST; fd("strst");
    e = st(3'd2); e.aluSrcB = 1'b1; e.seu = 2'd1; e.reg2Sel = 1'b1; push("strst_exec", e); step();
    e = st(3'd3); e.memWr = 1'b1; e.reg2Sel = 1'b1;
    push("strst_mem0", e); step();
    push("strst_mem1", e); step();
    #1;
    push("strst_mem2", e); check_now();
    rst_pulse("midmem");
    i_opCode = OP_ADD; fd("restart");
    push("restart_exec", st(3'd2)); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/legv8_multicycle_ctrl.md
Name: legv8_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the LEGv8 datapath: FETCH, DECODE, EXEC, MEM, WB.
- Per-state datapath controls share the encodings of the single-cycle control path: ALUOp, SEU, PCSrc and wrDataSel.
- Owns the NZ flag register, resolves branches, and handshakes with data memory (wait states, timeout).
- Sits between the IR/PC/register-file datapath and the data memory port.

Parameters:
MEM_TIMEOUT, 16, cycles in MEM without i_memAck before bus error; 0 disables the timeout.

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_opCode  in  11  IR[31:21], stable from DECODE until the next FETCH
i_bCond  in  4  IR[3:0]
i_Z  in  1  ALU zero flag, valid in EXEC
i_N  in  1  ALU negative flag, valid in EXEC
i_memAck  in  1  data-memory completion strobe
o_irWr  out  1  load IR
o_pcWr  out  1  write PC
o_PCSrc  out  2  0=PC+4, 1=PC-relative target (from old PC), 2=register (BR)
o_reg2Sel  out  1  0=Rm, 1=Rt
o_rfWr  out  1  register-file write
o_SEU  out  2  0=ALU_imm, 1=DT_addr, 2=BR_addr, 3=COND_BR_addr
o_ALUSrcB  out  1  0=reg, 1=immediate
o_ALUOp  out  4  0=add, 1=sub, 2=and, 3=orr, 6=lsl, 7=lsr, 8=pass B
o_memRd  out  1  data read request
o_memWr  out  1  data write request
o_wrDataSel  out  2  0=mem, 1=ALU, 2=PC+4
o_state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7
o_instRet  out  1  one-cycle pulse on the last cycle of each instruction
o_illegal  out  1  sticky; unknown opcode
o_busErr  out  1  sticky; memory timeout

Behaviour:
- Reset (async, i_rst_n low): state=FETCH; r_Z=r_N=0; timeout counter=0; stickies cleared; every output 0 while reset is asserted.
- Outputs are combinational from state plus the class register latched in DECODE. Any control not listed for a state is 0.
- FETCH: o_irWr=1, o_pcWr=1, PCSrc=0. Next state DECODE.
- DECODE: latch the class from i_opCode.
  - Classes: R = ADD/SUB/AND/ORR/LSL/LSR/ADDS/SUBS; I = ADDI/SUBI/SUBIS (opCode[10:1]); LD; ST; B; BL; BCOND; CBZ; CBNZ; BR.
  - Unknown opcode -> HALT, o_illegal=1.
  - Otherwise next state EXEC.
- EXEC, R and I classes:
  - ALUOp: ADD/ADDI/ADDS=0, SUB/SUBI/SUBS/SUBIS=1, AND=2, ORR=3, LSL=6, LSR=7.
  - I class: ALUSrcB=1, SEU=0.
  - ADDS/SUBS/SUBIS: r_Z<=i_Z, r_N<=i_N at the clock edge leaving EXEC.
  - Next state WB.
- EXEC, LD/ST: ALUOp=0, ALUSrcB=1, SEU=1. ST also sets reg2Sel=1. Next state MEM.
- EXEC, branches (3 cycles total). Each asserts o_pcWr with PCSrc=1 only if taken; o_instRet=1; next state FETCH.
  - B: SEU=2; always taken.
  - BL: SEU=2; always taken; also rfWr=1, wrDataSel=2 (X30 <- PC+4).
  - CBZ/CBNZ: reg2Sel=1, ALUOp=8, SEU=3. Taken if i_Z (CBZ) or !i_Z (CBNZ).
  - BCOND: SEU=3; uses the registered flags.
    - EQ 0000: Z. NE 0001: !Z. GE 1010: !N. LT 1011: N. GT 1100: !Z&!N. LE 1101: Z|N. AL 1110: taken.
    - Any other code: not taken.
  - BR: reg2Sel=1; PCSrc=2; o_pcWr=1 always.
- MEM:
  - LD holds o_memRd=1 (SEU/ALU controls held); ST holds o_memWr=1 with reg2Sel=1.
  - Remain in MEM until i_memAck=1.
  - On ack: LD -> WB; ST -> FETCH with o_instRet=1.
  - The counter increments on each MEM cycle without ack. When it reaches MEM_TIMEOUT -> HALT, o_busErr=1.
  - Counter clears on leaving MEM.
  - i_memAck outside MEM is ignored.
- WB: o_rfWr=1, o_instRet=1, next state FETCH.
  - R/I: wrDataSel=1, ALU controls held.
  - LD: wrDataSel=0.
- Latency (cycles per instruction): R/I 4; LD 5+waits; ST 4+waits; branches 3.
- HALT: all controls 0; only reset exits.
- Reset mid-MEM: requests drop immediately (asynchronous); restart at FETCH.

Test Plan:
- Reset then ADD (11'b10001011000) -> states 0,1,2,4; WB asserts rfWr=1, wrDataSel=1, ALUOp=0; o_instRet pulses in cycle 4.
- LDUR with i_memAck delayed 2 cycles -> memRd held 3 MEM cycles; then WB with wrDataSel=0; total 7 cycles.
- SUBIS giving i_Z=1, then B.cond bCond=0000 -> pcWr=1, PCSrc=1 in EXEC. Same with bCond=0001 -> pcWr=0.
- CBNZ with i_Z=1 -> not taken. BL -> rfWr=1, wrDataSel=2, pcWr=1 in the same EXEC cycle.
- Opcode 11'b00000000000 -> HALT (o_state=7), o_illegal=1, remains until reset.
- STUR with no ack, MEM_TIMEOUT=16 -> o_busErr=1 after 16 MEM cycles; asserting i_rst_n=0 mid-MEM clears memWr immediately.
